// File: rtl/d_e_reg_pkg.sv
// Core-wide constants shared by the pipeline registers.
// NOP encoding, write-back selects and widths.
package d_e_reg_pkg;

    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    localparam int TNEW_W = 2;
    localparam int WDS_W  = 2;
    localparam int A3_W   = 5;

    localparam logic [WDS_W-1:0] WD_ALU = 2'd0;
    localparam logic [WDS_W-1:0] WD_MEM = 2'd1;
    localparam logic [WDS_W-1:0] WD_PC8 = 2'd2;

    typedef logic [TNEW_W-1:0] tnew_t;
    typedef logic [WDS_W-1:0]  wd_sel_t;
    typedef logic [A3_W-1:0]   reg_idx_t;

endpackage

// File: rtl/d_e_reg_pipe_field.sv
// One pipeline-register field: async active-low reset,
// clear-to-value has priority over load.
module pipe_field #(
    parameter int          W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] clr_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RST_VAL;
        end else if (clear) begin
            q <= clr_val;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/d_e_reg.sv
// D/E pipeline register: turns stall into a bubble, flush
// into a cleared slot, and counts inserted bubbles.
import d_e_reg_pkg::*;

module d_e_reg #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      D_pc,
    input  logic [31:0]      D_instr,
    input  logic [31:0]      D_rs_data,
    input  logic [31:0]      D_rt_data,
    input  logic [31:0]      D_ext,
    input  logic [4:0]       D_A3,
    input  logic [1:0]       D_tnew,
    input  logic [1:0]       D_wd_sel,
    output logic [31:0]      E_pc,
    output logic [31:0]      E_instr,
    output logic [31:0]      E_rs_data,
    output logic [31:0]      E_rt_data,
    output logic [31:0]      E_ext,
    output logic [4:0]       E_A3,
    output logic [1:0]       E_tnew,
    output logic [1:0]       E_wd_sel,
    output logic             E_valid,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic bub;
    assign bub = flush | stall;

    // Stalled PC is kept for debug; only flush forces RESET_PC.
    pipe_field #(.W(32), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .reset(reset), .load(1'b1),
        .clear(flush), .clr_val(RESET_PC),
        .d(D_pc), .q(E_pc)
    );

    pipe_field #(.W(32)) u_instr (
        .clk(clk), .reset(reset), .load(1'b1),
        .clear(bub), .clr_val(NOP),
        .d(D_instr), .q(E_instr)
    );

    pipe_field #(.W(32)) u_rs (
        .clk(clk), .reset(reset), .load(1'b1),
        .clear(bub), .clr_val(32'h0),
        .d(D_rs_data), .q(E_rs_data)
    );

    pipe_field #(.W(32)) u_rt (
        .clk(clk), .reset(reset), .load(1'b1),
        .clear(bub), .clr_val(32'h0),
        .d(D_rt_data), .q(E_rt_data)
    );

    pipe_field #(.W(32)) u_ext (
        .clk(clk), .reset(reset), .load(1'b1),
        .clear(bub), .clr_val(32'h0),
        .d(D_ext), .q(E_ext)
    );

    pipe_field #(.W(A3_W)) u_a3 (
        .clk(clk), .reset(reset), .load(1'b1),
        .clear(bub), .clr_val(5'd0),
        .d(D_A3), .q(E_A3)
    );

    pipe_field #(.W(TNEW_W)) u_tnew (
        .clk(clk), .reset(reset), .load(1'b1),
        .clear(bub), .clr_val(2'd0),
        .d(D_tnew), .q(E_tnew)
    );

    pipe_field #(.W(WDS_W)) u_wds (
        .clk(clk), .reset(reset), .load(1'b1),
        .clear(bub), .clr_val(WD_ALU),
        .d(D_wd_sel), .q(E_wd_sel)
    );

    pipe_field #(.W(1)) u_valid (
        .clk(clk), .reset(reset), .load(1'b1),
        .clear(bub), .clr_val(1'b0),
        .d(1'b1), .q(E_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (stall && !flush && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_d_e_reg.sv
// Directed bench for d_e_reg: reset, load, stall, flush,
// counter saturation and async reset.
module tb_d_e_reg;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] D_pc, D_instr, D_rs_data, D_rt_data, D_ext;
    logic [4:0]  D_A3;
    logic [1:0]  D_tnew, D_wd_sel;
    logic [31:0] E_pc, E_instr, E_rs_data, E_rt_data, E_ext;
    logic [4:0]  E_A3;
    logic [1:0]  E_tnew, E_wd_sel;
    logic        E_valid;
    logic [3:0]  bubble_cnt;

    int errs;
    int checks;
    int exp_cnt;

    d_e_reg #(.RESET_PC(32'h0000_3000), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .stall(stall), .flush(flush),
        .D_pc(D_pc), .D_instr(D_instr),
        .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
        .D_ext(D_ext), .D_A3(D_A3),
        .D_tnew(D_tnew), .D_wd_sel(D_wd_sel),
        .E_pc(E_pc), .E_instr(E_instr),
        .E_rs_data(E_rs_data), .E_rt_data(E_rt_data),
        .E_ext(E_ext), .E_A3(E_A3),
        .E_tnew(E_tnew), .E_wd_sel(E_wd_sel),
        .E_valid(E_valid), .bubble_cnt(bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, ".pc"},    E_pc, 32'h0000_3000);
        check({tag, ".instr"}, E_instr, 32'h0);
        check({tag, ".rs"},    E_rs_data, 32'h0);
        check({tag, ".rt"},    E_rt_data, 32'h0);
        check({tag, ".ext"},   E_ext, 32'h0);
        check({tag, ".a3"},    32'(E_A3), 32'h0);
        check({tag, ".tnew"},  32'(E_tnew), 32'h0);
        check({tag, ".wds"},   32'(E_wd_sel), 32'h0);
        check({tag, ".valid"}, 32'(E_valid), 32'h0);
        check({tag, ".cnt"},   32'(bubble_cnt), 32'h0);
    endtask

    task automatic chk_bubble(input string tag,
                              input logic [31:0] pc,
                              input int cnt);
        check({tag, ".pc"},    E_pc, pc);
        check({tag, ".instr"}, E_instr, 32'h0);
        check({tag, ".rs"},    E_rs_data, 32'h0);
        check({tag, ".rt"},    E_rt_data, 32'h0);
        check({tag, ".ext"},   E_ext, 32'h0);
        check({tag, ".a3"},    32'(E_A3), 32'h0);
        check({tag, ".tnew"},  32'(E_tnew), 32'h0);
        check({tag, ".wds"},   32'(E_wd_sel), 32'h0);
        check({tag, ".valid"}, 32'(E_valid), 32'h0);
        check({tag, ".cnt"},   32'(bubble_cnt), 32'(cnt));
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        reset  = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;

        // reset held for 3 edges with random D inputs
        for (int i = 0; i < 3; i++) begin
            D_pc      = $urandom;
            D_instr   = $urandom;
            D_rs_data = $urandom;
            D_rt_data = $urandom;
            D_ext     = $urandom;
            D_A3      = 5'($urandom);
            D_tnew    = 2'($urandom);
            D_wd_sel  = 2'($urandom);
            step();
            chk_reset("rst");
        end

        // normal load on first edge after release
        reset     = 1'b1;
        D_pc      = 32'h0000_3004;
        D_instr   = 32'h0221_8021;
        D_rs_data = 32'd5;
        D_rt_data = 32'd7;
        D_ext     = 32'h0000_8021;
        D_A3      = 5'd16;
        D_tnew    = 2'd1;
        D_wd_sel  = 2'd0;
        step();
        check("ld.pc",    E_pc, 32'h0000_3004);
        check("ld.instr", E_instr, 32'h0221_8021);
        check("ld.rs",    E_rs_data, 32'd5);
        check("ld.rt",    E_rt_data, 32'd7);
        check("ld.ext",   E_ext, 32'h0000_8021);
        check("ld.a3",    32'(E_A3), 32'd16);
        check("ld.tnew",  32'(E_tnew), 32'd1);
        check("ld.wds",   32'(E_wd_sel), 32'd0);
        check("ld.valid", 32'(E_valid), 32'd1);
        check("ld.cnt",   32'(bubble_cnt), 32'd0);

        // lw-use hazard: three stalls
        D_pc      = 32'h0000_3008;
        D_instr   = 32'h8d09_0004;
        D_rs_data = 32'd9;
        D_rt_data = 32'd3;
        D_ext     = 32'd4;
        D_A3      = 5'd9;
        D_tnew    = 2'd2;
        D_wd_sel  = 2'd1;
        stall     = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_bubble("stl", 32'h0000_3008, i);
        end

        stall = 1'b0;
        step();
        check("rel.pc",    E_pc, 32'h0000_3008);
        check("rel.instr", E_instr, 32'h8d09_0004);
        check("rel.rs",    E_rs_data, 32'd9);
        check("rel.a3",    32'(E_A3), 32'd9);
        check("rel.tnew",  32'(E_tnew), 32'd2);
        check("rel.wds",   32'(E_wd_sel), 32'd1);
        check("rel.valid", 32'(E_valid), 32'd1);
        check("rel.cnt",   32'(bubble_cnt), 32'd3);

        // flush wins over stall; counter frozen
        flush = 1'b1;
        stall = 1'b1;
        D_pc  = 32'h0000_300c;
        D_A3  = 5'd31;
        step();
        chk_bubble("fl", 32'h0000_3000, 3);

        // X on D inputs must not leak into a bubble
        flush     = 1'b0;
        D_pc      = 32'h0000_3010;
        D_instr   = 'x;
        D_rs_data = 'x;
        D_rt_data = 'x;
        D_ext     = 'x;
        D_A3      = 'x;
        D_tnew    = 'x;
        D_wd_sel  = 'x;
        step();
        chk_bubble("xs", 32'h0000_3010, 4);

        // saturation with E_pc tracking D_pc
        D_instr   = 32'h0;
        D_rs_data = 32'h0;
        D_rt_data = 32'h0;
        D_ext     = 32'h0;
        D_A3      = 5'd1;
        D_tnew    = 2'd1;
        D_wd_sel  = 2'd2;
        exp_cnt   = 4;
        for (int i = 0; i < 20; i++) begin
            D_pc = 32'h0000_3100 + 32'(4 * i);
            step();
            if (exp_cnt < 15) exp_cnt++;
            check("sat.pc", E_pc, 32'h0000_3100 + 32'(4 * i));
            check("sat.cnt", 32'(bubble_cnt), 32'(exp_cnt));
            check("sat.a3", 32'(E_A3), 32'h0);
        end

        // async reset between edges after a load
        stall     = 1'b0;
        D_pc      = 32'h0000_3200;
        D_instr   = 32'h2008_0001;
        D_rs_data = 32'd11;
        D_A3      = 5'd8;
        D_tnew    = 2'd1;
        D_wd_sel  = 2'd0;
        step();
        check("pre.a3",    32'(E_A3), 32'd8);
        check("pre.valid", 32'(E_valid), 32'd1);
        check("pre.cnt",   32'(bubble_cnt), 32'd15);
        #2;
        reset = 1'b0;
        #1;
        chk_reset("arst");
        step();
        chk_reset("arst2");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end

endmodule
